muladd_rr_scheduler: RTL and testbench
======================================

# muladd_rr_scheduler

Round-robin scheduler that shares one pipelined signed multiply-add DSP (`dout = din0*din1 + din2`, three clock-enabled register stages) between `N_REQ` independent requesters. It arbitrates at most one issue per enabled cycle and drives the DSP operands. It tracks each in-flight operation with a tag pipeline that matches the DSP latency, then steers each result back to the requester that issued it. It sits between the HLS-generated kernel ports and a single `muladd_DSP` instance, and replaces one DSP per requester.

## Interface

Parameters:

- `N_REQ`, default 4: number of requesters, from 2 to 8.
- `LAT`, default 3: DSP latency in ce-qualified cycles, from operand sample to `dsp_dout` valid.

Ports:

- `ap_clk`, in, 1: single clock for all logic.
- `ap_rst`, in, 1: reset, synchronous and active-high.
- `ap_ce`, in, 1: global clock enable. While it is low, the arbiter, the tag pipeline and the DSP hold their state.
- `req_valid`, in, `N_REQ`: request valid, one bit per requester.
- `req_ready`, out, `N_REQ`: request accepted this cycle (one-hot or zero).
- `req_a`, in, `N_REQ*27`: multiplicand A, signed; requester i occupies `[27i+26:27i]`.
- `req_b`, in, `N_REQ*18`: multiplicand B, signed; same packing.
- `req_c`, in, `N_REQ*48`: addend C, signed; same packing.
- `dsp_ce`, out, 1: equal to `ap_ce`.
- `dsp_din0`, out, 27: selected A.
- `dsp_din1`, out, 18: selected B.
- `dsp_din2`, out, 48: selected C.
- `dsp_dout`, in, 48: DSP result.
- `rsp_valid`, out, `N_REQ`: result valid for requester i (one-hot or zero).
- `rsp_data`, out, 48: equal to `dsp_dout`, shared by all requesters.
- `inflight`, out, `$clog2(LAT+1)`: number of operations currently in the DSP pipeline.

## Operation

- **Arbitration**
  - The arbiter keeps a round-robin pointer `last`, the index of the most recent grant.
  - The search starts at `(last+1) mod N_REQ` and wraps around.
  - The first requester with `req_valid` set is granted.
  - The grant is combinational: `req_ready[i] = ap_ce & ~ap_rst & grant[i]`.
  - `last` updates only on a cycle where an issue occurs.
- **Issue**
  - On a grant, `dsp_din0/1/2` carry the granted requester's A/B/C.
  - With no grant, the operand outputs carry zeros. They are don't-care for correctness, but zeros are required for determinism.
  - A transfer completes in a cycle only when `req_valid[i]` and `req_ready[i]` are both high.
  - Requesters must hold their operands stable until they see `req_ready`.
- **Tag pipeline**
  - The tag pipeline has `LAT` stages. Each stage holds `{v, id[$clog2(N_REQ)-1:0]}`.
  - On each `ap_ce` cycle: stage 0 loads `{issue, granted id}`, and stage k loads stage k-1.
  - When `ap_ce` is low, every stage holds its value.
- **Response**
  - `rsp_valid[i] = ap_ce & tag[LAT-1].v & (tag[LAT-1].id == i)`.
  - `rsp_data = dsp_dout`.
  - Responses have no backpressure: requesters must capture `rsp_data` in the cycle `rsp_valid` is asserted.
  - Qualifying `rsp_valid` with `ap_ce` means a frozen pipeline never produces a duplicate pulse.
- **Inflight counter**
  - `inflight` is a registered count equal to the number of set `v` bits in the tag stages.
  - It is maintained incrementally: +1 on issue, −1 on retire, unchanged when both happen together. It never exceeds `LAT`.
- **Arithmetic**
  - All three operands are signed two's complement. The result is `A*B + C`, truncated to 48 bits, and wraps on overflow.
  - The block itself computes nothing. The verification model uses this formula.
- **Reset** (`ap_rst`, synchronous, takes priority over `ap_ce`)
  - All tag `v` bits clear, `inflight` goes to 0, and `last` goes to `N_REQ-1`, so requester 0 is first in priority after reset.
  - Outputs during and after reset: `req_ready=0`, `rsp_valid=0`, `dsp_din*=0`. `dsp_ce` follows `ap_ce`.
  - Operations in flight when reset is asserted are dropped: their responses are never signalled, even though the DSP data registers are not reset.

## Timing

- Requests accepted in cycle t (with `ap_ce` high) produce `rsp_valid` in the `LAT`-th subsequent `ap_ce`-high cycle. With `ap_ce` held high, that is cycle t+`LAT`.
- Throughput is one issue per `ap_ce` cycle, in aggregate across all requesters.
- Fairness: a requester that holds `req_valid` high is granted within `N_REQ` issue cycles.
- Simultaneous issue and retire in the same cycle is allowed and is the steady state.
- `ap_ce` low in cycle t:
  - no grant;
  - no response pulse;
  - the tags, `last` and `inflight` all hold;
  - the DSP holds, so `dsp_dout` is stable when `ap_ce` returns.
- Combinational paths: `req_valid` to `req_ready` and `req_valid` to `dsp_din*`. No path runs from `dsp_dout` to `req_ready`.

## Test plan

- **Single request**, default parameters: requester 2 issues A=−3, B=5, C=100 at cycle 10 → `req_ready[2]` is high at cycle 10; `rsp_valid=4'b0100` and `rsp_data=85` at cycle 13; `inflight` reads 1 during cycles 11–13 and 0 at cycle 14.
- **All requesters valid**, starting from cycle 0 after reset: grants go to requesters 0, 1, 2, 3, 0 in cycles 0–4; responses appear in cycles 3–7 in the same order with correct values; `inflight` saturates at 3.
- **Fairness**: requester 0 is valid every cycle and requester 3 asserts valid once → requester 3 is granted within 4 cycles; requester 0 is never granted twice in a row while requester 3 is waiting.
- **ce stall**: issue at cycle 5, drop `ap_ce` for cycles 6–8 → no `req_ready` and no `rsp_valid` during the stall; the response appears at cycle 11 with the correct value and exactly one pulse.
- **Reset mid-flight**: issue 3 operations, then assert `ap_rst` for one cycle while they are in flight → no `rsp_valid` for any of them; `inflight` is 0 and the next grant goes to requester 0.
- **Overflow**: A=2^26−1, B=2^17−1, C=2^47−1 → `rsp_data` equals the 48-bit wrapped sum.

Source files
------------

// File: rtl/muladd_rr_scheduler.sv
// Round-robin front end sharing one pipelined multiply-add DSP between N_REQ requesters.
// A tag pipeline matched to the DSP latency routes each result back to the requester that issued it.
module muladd_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int LAT   = 3
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       ap_ce,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*27-1:0]        req_a,
  input  logic [N_REQ*18-1:0]        req_b,
  input  logic [N_REQ*48-1:0]        req_c,
  output logic                       dsp_ce,
  output logic [26:0]                dsp_din0,
  output logic [17:0]                dsp_din1,
  output logic [47:0]                dsp_din2,
  input  logic [47:0]                dsp_dout,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [47:0]                rsp_data,
  output logic [$clog2(LAT+1)-1:0]   inflight
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(LAT+1);

  logic [IDW-1:0]   r_last;
  logic [LAT-1:0]   r_tag_v;
  logic [IDW-1:0]   r_tag_id [LAT];
  logic [CW-1:0]    r_inflight;

  logic             w_found;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_gid;
  logic             w_issue;
  logic             w_retire;
  logic [N_REQ-1:0] w_grant;
  logic [N_REQ-1:0] w_rsp_valid;

  // Search starts just after the most recent grant and wraps around.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = IDW'((int'(r_last) + 1 + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gid   = w_idx;
      end
    end
  end

  assign w_issue  = w_found & ap_ce & ~ap_rst;
  assign w_retire = r_tag_v[LAT-1];

  always_comb begin
    w_grant = '0;
    if (w_issue) w_grant[w_gid] = 1'b1;
  end

  // Gating with ap_rst too keeps results of dropped operations from escaping in the reset cycle.
  always_comb begin
    w_rsp_valid = '0;
    if (ap_ce && !ap_rst && w_retire) w_rsp_valid[r_tag_id[LAT-1]] = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_tag_v    <= '0;
      r_inflight <= '0;
      r_last     <= IDW'(N_REQ-1);
    end else if (ap_ce) begin
      r_tag_v[0]  <= w_issue;
      r_tag_id[0] <= w_gid;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
      if (w_issue) r_last <= w_gid;
      case ({w_issue, w_retire})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign dsp_ce    = ap_ce;
  assign dsp_din0  = w_issue ? req_a[w_gid*27 +: 27] : '0;
  assign dsp_din1  = w_issue ? req_b[w_gid*18 +: 18] : '0;
  assign dsp_din2  = w_issue ? req_c[w_gid*48 +: 48] : '0;
  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = dsp_dout;
  assign inflight  = r_inflight;

endmodule

// File: tb/tb_muladd_rr_scheduler.sv
// Bench for muladd_rr_scheduler: a behavioural DSP plus a queue-based scheduler model
// checked every cycle, with hand-computed literals for the directed scenarios.
module tb_muladd_rr_scheduler;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ap_ce;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*27-1:0] req_a;
  logic [N*18-1:0] req_b;
  logic [N*48-1:0] req_c;
  logic          dsp_ce;
  logic [26:0]   dsp_din0;
  logic [17:0]   dsp_din1;
  logic [47:0]   dsp_din2;
  logic [47:0]   dsp_dout;
  logic [N-1:0]  rsp_valid;
  logic [47:0]   rsp_data;
  logic [1:0]    inflight;

  logic [26:0] op_a [N];
  logic [17:0] op_b [N];
  logic [47:0] op_c [N];

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 ap_clk = ~ap_clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    req_c = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*27 +: 27] = op_a[i];
      req_b[i*18 +: 18] = op_b[i];
      req_c[i*48 +: 48] = op_c[i];
    end
  end

  muladd_rr_scheduler #(.N_REQ(N), .LAT(LAT)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .dsp_ce(dsp_ce), .dsp_din0(dsp_din0), .dsp_din1(dsp_din1), .dsp_din2(dsp_din2),
    .dsp_dout(dsp_dout), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight)
  );

  // Three-stage clock-enabled DSP, no reset on its data registers.
  logic signed [26:0] d_a;
  logic signed [17:0] d_b;
  logic signed [47:0] d_c1, d_c2, d_m, d_p;
  always @(posedge ap_clk) begin
    if (dsp_ce) begin
      d_a  <= dsp_din0;
      d_b  <= dsp_din1;
      d_c1 <= dsp_din2;
      d_m  <= d_a * d_b;
      d_c2 <= d_c1;
      d_p  <= d_m + d_c2;
    end
  end
  assign dsp_dout = d_p;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [47:0] muladd(input logic [26:0] a, input logic [17:0] b,
                                          input logic [47:0] c);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
    return p[47:0];
  endfunction

  // Scheduler model: pending ops count down the ce-high cycles left until their response.
  typedef struct {
    int          id;
    int          rem;
    logic [47:0] val;
  } op_t;
  op_t pend[$];
  int  m_last = N-1;

  always @(negedge ap_clk) begin
    if (chk_en) begin
      int          gi;
      logic [N-1:0] e_ready, e_rsp;
      logic [26:0] e_d0;
      logic [17:0] e_d1;
      logic [47:0] e_d2, e_data;
      gi = -1;
      e_ready = '0; e_rsp = '0; e_d0 = '0; e_d1 = '0; e_d2 = '0; e_data = '0;
      if (ap_ce && !ap_rst) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_last + 1 + k) % N;
          if (gi < 0 && req_valid[idx]) gi = idx;
        end
      end
      if (gi >= 0) begin
        e_ready[gi] = 1'b1;
        e_d0 = op_a[gi]; e_d1 = op_b[gi]; e_d2 = op_c[gi];
      end
      foreach (pend[j]) begin
        if (pend[j].rem == 1 && ap_ce && !ap_rst) begin
          e_rsp[pend[j].id] = 1'b1;
          e_data = pend[j].val;
        end
      end
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("dsp_din0",  64'(dsp_din0),  64'(e_d0));
      chk("dsp_din1",  64'(dsp_din1),  64'(e_d1));
      chk("dsp_din2",  64'(dsp_din2),  64'(e_d2));
      chk("dsp_ce",    64'(dsp_ce),    64'(ap_ce));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      chk("inflight",  64'(inflight),  64'(pend.size()));
      if (e_rsp != '0) chk("rsp_data", 64'(rsp_data), 64'(e_data));

      if (ap_rst) begin
        pend.delete();
        m_last = N-1;
      end else if (ap_ce) begin
        for (int j = pend.size()-1; j >= 0; j--) begin
          pend[j].rem--;
          if (pend[j].rem == 0) pend.delete(j);
        end
        if (gi >= 0) begin
          pend.push_back('{id: gi, rem: LAT, val: muladd(op_a[gi], op_b[gi], op_c[gi])});
          m_last = gi;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  typedef struct { logic [N-1:0] v; logic ce; } mix_t;
  mix_t mix [8] = '{'{4'b1010,1'b1}, '{4'b0110,1'b0}, '{4'b0111,1'b1}, '{4'b1111,1'b1},
                    '{4'b0001,1'b0}, '{4'b1001,1'b1}, '{4'b0000,1'b1}, '{4'b1100,1'b1}};

  initial begin
    int got3, grant_cyc, pulses, pulse_cyc;
    logic [47:0] pulse_data;
    ap_rst = 1'b1; ap_ce = 1'b1; req_valid = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_c[i] = '0;
    end
    cyc();
    chk_en = 1'b1;
    #3;
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_inflight", 64'(inflight), 64'd0);
    cyc(); cyc();

    // All requesters valid from the first cycle out of reset.
    for (int i = 0; i < N; i++) begin
      op_a[i] = 27'(i + 1);
      op_b[i] = 18'(-(i + 2));
      op_c[i] = 48'(1000 * i);
    end
    ap_rst = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("all_grant_order", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      chk("all_inflight", 64'(inflight), 64'((k < 3) ? k : 3));
      cyc();
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) cyc();

    // Single request from requester 2.
    op_a[2] = 27'(-3); op_b[2] = 18'd5; op_c[2] = 48'd100;
    req_valid = 4'b0100;
    #3; chk("single_ready", 64'(req_ready), 64'(4'b0100));
    cyc(); req_valid = '0;
    #3; chk("single_inflight_t1", 64'(inflight), 64'd1);
    cyc(); cyc();
    #3;
    chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("single_rsp_data", 64'(rsp_data), 64'd85);
    chk("single_inflight_t3", 64'(inflight), 64'd1);
    cyc();
    #3; chk("single_inflight_t4", 64'(inflight), 64'd0);
    cyc();

    // Fairness: requester 0 always valid, requester 3 raises valid once and holds it.
    got3 = 0; grant_cyc = -1;
    for (int k = 0; k < 6; k++) begin
      req_valid = {(k >= 1 && got3 == 0), 2'b00, 1'b1};
      #3;
      if (k == 0) chk("fair_first_grant", 64'(req_ready), 64'(4'b0001));
      if (req_ready[3] && got3 == 0) begin got3 = 1; grant_cyc = k; end
      cyc();
    end
    chk("fair_r3_granted", 64'(got3), 64'd1);
    chk("fair_r3_cycle", 64'(grant_cyc), 64'd1);
    req_valid = '0;
    for (int k = 0; k < 4; k++) cyc();

    // ce stall: issue, freeze three cycles, then resume.
    op_a[1] = 27'd7; op_b[1] = 18'(-9); op_c[1] = 48'(-1000);
    pulses = 0; pulse_cyc = -1; pulse_data = '0;
    req_valid = 4'b0010;
    #3; chk("stall_issue_ready", 64'(req_ready), 64'(4'b0010));
    cyc();
    req_valid = 4'b1000;
    ap_ce = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) ap_ce = 1'b1;
      #3;
      if (k <= 3) begin
        chk("stall_no_ready", 64'(req_ready), 64'd0);
        chk("stall_no_rsp", 64'(rsp_valid), 64'd0);
      end
      if (k == 4) chk("stall_resume_grant", 64'(req_ready), 64'(4'b1000));
      if (rsp_valid[1]) begin pulses++; pulse_cyc = k; pulse_data = rsp_data; end
      cyc();
      if (k == 4) req_valid = '0;
    end
    chk("stall_pulses", 64'(pulses), 64'd1);
    chk("stall_pulse_cycle", 64'(pulse_cyc), 64'd6);
    chk("stall_rsp_data", 64'(pulse_data), 64'(48'hFFFF_FFFF_FBD9));

    // Reset while three operations are in flight.
    req_valid = 4'b1111;
    cyc(); cyc(); cyc();
    req_valid = '0;
    ap_rst = 1'b1;
    #3; chk("rst_mid_no_rsp0", 64'(rsp_valid), 64'd0);
    cyc();
    ap_rst = 1'b0;
    #3;
    chk("rst_mid_inflight", 64'(inflight), 64'd0);
    chk("rst_mid_no_rsp1", 64'(rsp_valid), 64'd0);
    cyc();
    #3; chk("rst_mid_no_rsp2", 64'(rsp_valid), 64'd0);
    cyc();
    req_valid = 4'b1111;
    #3; chk("rst_mid_next_grant", 64'(req_ready), 64'(4'b0001));
    cyc();
    req_valid = '0;
    for (int k = 0; k < 4; k++) cyc();

    // Overflow wraps to 48 bits.
    op_a[1] = 27'h3FF_FFFF; op_b[1] = 18'h1_FFFF; op_c[1] = 48'h7FFF_FFFF_FFFF;
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    cyc(); cyc();
    #3;
    chk("ovf_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("ovf_rsp_data", 64'(rsp_data), 64'(48'h87FF_FBFE_0000));
    cyc();

    // Mixed valid/ce pattern, checked by the model.
    for (int i = 0; i < N; i++) begin
      op_a[i] = 27'(-(17 * i + 5));
      op_b[i] = 18'(301 * i - 400);
      op_c[i] = 48'(i * 77777 - 12345);
    end
    foreach (mix[j]) begin
      req_valid = mix[j].v;
      ap_ce = mix[j].ce;
      cyc();
    end
    req_valid = '0;
    ap_ce = 1'b1;
    for (int k = 0; k < 6; k++) cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
